// File: rtl/alu_pkg.sv
// alu_pkg -- shared constants and types for the 32-bit execute ALU.
//   DATA_W   : datapath width (32)
//   SHAMT_W  : SRL shift-amount width (5)
//   OP_*     : 4-bit operation codes
//   state_t  : control FSM state encoding
// Optional feature macro: ALU_CARRY_EN (carry flag and ADC op).
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int OP_W    = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_AND   = 4'd1;
  localparam logic [OP_W-1:0] OP_OR    = 4'd2;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd3;
  localparam logic [OP_W-1:0] OP_NOR   = 4'd4;
  localparam logic [OP_W-1:0] OP_SRL   = 4'd5;
  localparam logic [OP_W-1:0] OP_EXT   = 4'd6;
  localparam logic [OP_W-1:0] OP_ORBIT = 4'd7;
  localparam logic [OP_W-1:0] OP_ADC   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_comb_32.sv
// alu_comb_32 -- combinational result logic for every op except SRL.
// Ports:
//   op        : operation code
//   a, b      : 32-bit operands
//   imm       : 16-bit immediate for EXT
//   result    : computed result (0 for SRL and undefined codes)
//   carry_in  : stored carry flag, feeds ADC          (ALU_CARRY_EN only)
//   carry_out : bit 32 of the (possibly carry-in) sum (ALU_CARRY_EN only)
//   carry_we  : op updates the carry flag             (ALU_CARRY_EN only)
// Optional feature macro: ALU_CARRY_EN.
module alu_comb_32
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [15:0]       imm,
  output logic [DATA_W-1:0] result
`ifdef ALU_CARRY_EN
  ,
  input  logic              carry_in,
  output logic              carry_out,
  output logic              carry_we
`endif
);

`ifdef ALU_CARRY_EN
  // 33-bit sum shared by ADD and ADC; the stored carry only enters for ADC.
  logic              adc_cin;
  logic [DATA_W:0]   sum;

  assign adc_cin   = (op == OP_ADC) & carry_in;
  assign sum       = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, adc_cin};
  assign carry_out = sum[DATA_W];
  assign carry_we  = (op == OP_ADD) || (op == OP_ADC);
`else
  // Without the carry flag only the low 32 bits of the sum are observable.
  logic [DATA_W-1:0] sum;

  assign sum = a + b;
`endif

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:   result = sum[DATA_W-1:0];
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOR:   result = ~(a | b);
      OP_EXT:   result = {{(DATA_W-16){imm[15]}}, imm};
      OP_ORBIT: result = {{(DATA_W-1){1'b0}}, |a};
`ifdef ALU_CARRY_EN
      OP_ADC:   result = sum[DATA_W-1:0];
`endif
      // SRL is handled by the shifter register in the top; undefined codes
      // give zero.
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_32.sv
// alu_exec_32 -- 32-bit execute ALU with a valid/ready handshake on both
// sides, an iterative 1-bit-per-cycle logical right shifter and flags.
// Ports:
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  : operation handshake (ready only in IDLE)
//   op, a, b, shamt, imm : operation and operands, captured on accept
//   out_valid/out_ready: result handshake (valid only in DONE)
//   result             : registered result
//   zero               : result == 0
//   carry              : stored carry flag (tied 0 without ALU_CARRY_EN)
// Optional feature macro: ALU_CARRY_EN (carry flag and ADC op).
module alu_exec_32
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [15:0]        imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               zero,
  output logic               carry
);

  state_t               state_reg;
  logic [DATA_W-1:0]    result_reg;
  logic [SHAMT_W-1:0]   count_reg;
  logic [DATA_W-1:0]    comb_result;
  logic                 accept;

`ifdef ALU_CARRY_EN
  logic                 carry_reg;
  logic                 comb_carry;
  logic                 comb_carry_we;
`endif

  assign accept = in_valid && (state_reg == ST_IDLE);

  alu_comb_32 u_comb (
    .op        (op),
    .a         (a),
    .b         (b),
    .imm       (imm),
    .result    (comb_result)
`ifdef ALU_CARRY_EN
    ,
    .carry_in  (carry_reg),
    .carry_out (comb_carry),
    .carry_we  (comb_carry_we)
`endif
  );

  // Control FSM, shifter and result register. SRL loads a on accept and
  // then shifts once per SHIFT cycle; the last shift happens on the edge
  // that enters DONE, so out_valid appears N+1 cycles after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      count_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_SRL) begin
              result_reg <= a;
              count_reg  <= shamt;
              state_reg  <= (shamt == '0) ? ST_DONE : ST_SHIFT;
            end else begin
              result_reg <= comb_result;
              state_reg  <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          result_reg <= result_reg >> 1;
          count_reg  <= count_reg - SHAMT_W'(1);
          if (count_reg == SHAMT_W'(1)) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_CARRY_EN
  // Only ADD and ADC touch the flag; SRL never asserts comb_carry_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_reg <= 1'b0;
    end else if (accept && comb_carry_we) begin
      carry_reg <= comb_carry;
    end
  end

  assign carry = carry_reg;
`else
  assign carry = 1'b0;
`endif

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign zero      = (result_reg == '0);

endmodule

// File: doc/alu_exec_32.md
ALU_EXEC_32 -- requirements
Module: alu_exec_32

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows: clk, input, 1 bit, rising-edge clock.
REQ-002 rst, input, 1 bit, synchronous active-high reset.
REQ-003 in_valid, input, 1 bit: the operation on op/a/b/shamt/imm is presented.
REQ-004 in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-005 op, input, 4 bits: operation code.
  - 0 ADD, 1 AND, 2 OR, 3 XOR, 4 NOR, 5 SRL, 6 EXT, 7 ORBIT, 8 ADC.
REQ-006 a, input, 32 bits: operand A.
REQ-007 b, input, 32 bits: operand B.
REQ-008 shamt, input, 5 bits: SRL shift amount.
REQ-009 imm, input, 16 bits: EXT immediate.
REQ-010 out_valid, output, 1 bit: result, zero and carry are valid.
REQ-011 out_ready, input, 1 bit: the consumer takes the result.
REQ-012 result, output, 32 bits: registered result.
REQ-013 zero, output, 1 bit: result == 0.
REQ-014 carry, output, 1 bit: stored carry flag.

Function
REQ-015 The control FSM SHALL have states IDLE, SHIFT and DONE.
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
REQ-016 An operation SHALL be accepted on a rising edge where in_valid && in_ready; all inputs are captured at that edge.
REQ-017 For every op except SRL, IDLE SHALL go to DONE with result loaded at the accept edge, giving out_valid one cycle after acceptance.
REQ-018 The ops SHALL compute:
  - ADD: a+b mod 2^32.
  - AND/OR/XOR/NOR: bitwise.
  - EXT: {{16{imm[15]}}, imm}.
  - ORBIT: {31'b0, |a}.
REQ-019 SRL with shamt=0 SHALL go IDLE->DONE with result=a.
REQ-020 SRL with shamt=N>0 SHALL load a, enter SHIFT, and shift logically right by 1 bit per cycle for N cycles, then go to DONE; out_valid is asserted N+1 cycles after acceptance.
REQ-021 DONE SHALL hold result/out_valid stable until out_ready=1, then go to IDLE on that edge; acceptance is not possible in the same cycle, so throughput is at most one operation per 2 cycles.
REQ-022 Undefined op codes (9-15) SHALL produce result=0 with 1-cycle latency and leave carry unchanged.
REQ-023 zero SHALL be driven combinationally from the result register.
REQ-024 in_valid in SHIFT/DONE SHALL be ignored without being lost by the block; the producer holds it.

Reset
REQ-025 On rst=1 at a rising edge, the block SHALL take the following values, overriding any handshake:
  - state=IDLE, result=0, carry=0.
  - hence in_ready=1, out_valid=0, zero=1.
REQ-026 Reset during SHIFT or DONE SHALL abort the operation, with no output produced.

Configuration
REQ-027 With macro ALU_CARRY_EN defined, the carry handling SHALL be:
  - ADD SHALL update carry with bit 32 of a+b.
  - ADC SHALL compute a+b+carry and update carry with its carry-out.
  - All other ops leave carry unchanged.
REQ-028 Without ALU_CARRY_EN, the carry handling SHALL be:
  - the carry register is absent and carry is tied to 0.
  - op 8 is treated as an undefined op (REQ-022).

Structure
REQ-029 Package alu_pkg SHALL hold:
  - the data-width constant (32);
  - the shift-amount width (5);
  - the op-code constants;
  - the FSM state encoding.
REQ-030 A combinational sub-module alu_comb_32 SHALL compute all non-SRL results (and the 33-bit sum); alu_exec_32 holds the FSM, the shifter register and the flags.

Verification
REQ-031 ADD a=A5A5A5A5, b=5A5A5A5A:
  - result=FFFFFFFF one cycle after acceptance, zero=0.
  - AND of the same operands -> 00000000, zero=1.
  - XOR of the same operands -> FFFFFFFF.
REQ-032 SRL a=A5A5A5A5, shamt=3:
  - in_ready=0 during SHIFT.
  - result=14B4B4B4 with out_valid 4 cycles after acceptance.
  - shamt=0 -> A5A5A5A5 after 1 cycle.
REQ-033 EXT with imm=FEBF (-321) -> FFFFFEBF; EXT with imm=007B (123) -> 0000007B.
REQ-034 With ALU_CARRY_EN, the sequence SHALL give:
  - ADD FFFFFFFF+00000001 -> 00000000, zero=1, carry=1.
  - then ADC F1111110+0EEEEEEF -> 00000000, carry=1.
  - then ADC 0+0 -> 00000001, carry=0.
  - without the macro, carry stays 0 and op 8 -> 0.
REQ-035 Backpressure: with out_ready=0 for 3 cycles after an OR result, result/out_valid SHALL hold and in_ready stays 0; out_ready=1 -> IDLE on the next edge.
REQ-036 Assert rst in the 2nd cycle of SRL shamt=20: the next cycle shows out_valid=0, in_ready=1, result=0, and no late output appears.
